snake_collision_engine: RTL and testbench

Parametrised successor to the snake collision controller. It resolves one snake move per `step` pulse: head-versus-body checks run as a sequential scan, one segment per cycle. Head-versus-apple and head-versus-wall checks are multi-channel. It maintains points, sticky lose/win flags and per-apple hit pulses for the game-logic and display blocks. It sits between the snake movement block, which supplies positions, and the scoring/VGA logic.

---
 rtl/snake_pkg.sv | 8 +
 rtl/snake_pos_match.sv | 17 +
 rtl/snake_collision_engine.sv | 145 ++++++++++++++
 tb/tb_snake_collision_engine.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared state encoding and flattened-vector width helpers for the collision engine
package snake_pkg;
  localparam int COORD_W_DEF = 11;
  typedef enum logic [1:0] {IDLE, SCAN, RESOLVE} state_t;
  function automatic int flat_w(input int n, input int w);
    return n * w;
  endfunction
endpackage

// File: rtl/snake_pos_match.sv
// snake_pos_match: combinational N-way equality of a head cell against a flattened position list
module snake_pos_match
  import snake_pkg::*;
#(
  parameter int N       = 2,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic [COORD_W-1:0]            head_x,
  input  logic [COORD_W-1:0]            head_y,
  input  logic [flat_w(N, COORD_W)-1:0] pos_x,
  input  logic [flat_w(N, COORD_W)-1:0] pos_y,
  output logic [N-1:0]                  hit
);
  for (genvar g = 0; g < N; g++) begin : g_cmp
    assign hit[g] = (pos_x[g*COORD_W +: COORD_W] == head_x) && (pos_y[g*COORD_W +: COORD_W] == head_y);
  end
endmodule

// File: rtl/snake_collision_engine.sv
// snake_collision_engine: resolves one snake move per step (serial body scan, parallel apple/wall checks, scoring)
module snake_collision_engine
  import snake_pkg::*;
#(
  parameter int COORD_W      = COORD_W_DEF,
  parameter int MAX_LEN      = 23,
  parameter int LEN_W        = 6,
  parameter int N_APPLES     = 2,
  parameter int N_WALLS      = 4,
  parameter int POINT_W      = 6,
  parameter int START_POINTS = 2,
  parameter int WIN_POINTS   = 9
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   step,
  input  logic [flat_w(MAX_LEN, COORD_W)-1:0]    snakepos_x,
  input  logic [flat_w(MAX_LEN, COORD_W)-1:0]    snakepos_y,
  input  logic [LEN_W-1:0]                       length,
  input  logic [flat_w(N_APPLES, COORD_W)-1:0]   applepos_x,
  input  logic [flat_w(N_APPLES, COORD_W)-1:0]   applepos_y,
  input  logic [flat_w(N_WALLS, COORD_W)-1:0]    wallpos_x,
  input  logic [flat_w(N_WALLS, COORD_W)-1:0]    wallpos_y,
  output logic                                   busy,
  output logic                                   done,
  output logic [N_APPLES-1:0]                    apple_hit,
  output logic                                   wall_hit,
  output logic [POINT_W-1:0]                     points,
  output logic                                   lose,
  output logic                                   win
);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t                state_q, state_d;
  logic [COORD_W-1:0]    head_x_q, head_x_d, head_y_q, head_y_d;
  logic [LEN_W-1:0]      len_q, len_d, idx_q, idx_d, len_eff, last_idx;
  logic                  body_q, body_d;
  logic [N_APPLES-1:0]   amatch_q, amatch_d, amatch_now, apple_hit_q, apple_hit_d;
  logic [N_WALLS-1:0]    wmatch_q, wmatch_d, wmatch_now;
  logic                  wall_hit_q, wall_hit_d, done_q, done_d, lose_q, lose_d, win_q, win_d;
  logic [POINT_W-1:0]    points_q, points_d, new_points;
  logic [POINT_W:0]      sum;
  logic                  accept, seg_hit, a, w, lose_set, win_set;
  logic [COORD_W-1:0]    seg_x [MAX_LEN];
  logic [COORD_W-1:0]    seg_y [MAX_LEN];

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_seg
    assign seg_x[g] = snakepos_x[g*COORD_W +: COORD_W];
    assign seg_y[g] = snakepos_y[g*COORD_W +: COORD_W];
  end

  snake_pos_match #(.N(N_APPLES), .COORD_W(COORD_W)) u_apple (
    .head_x(seg_x[0]), .head_y(seg_y[0]), .pos_x(applepos_x), .pos_y(applepos_y), .hit(amatch_now)
  );

  snake_pos_match #(.N(N_WALLS), .COORD_W(COORD_W)) u_wall (
    .head_x(seg_x[0]), .head_y(seg_y[0]), .pos_x(wallpos_x), .pos_y(wallpos_y), .hit(wmatch_now)
  );

  assign len_eff  = (length == '0) ? LEN_W'(1) : (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;
  assign last_idx = len_q - LEN_W'(1);
  assign accept   = step && (state_q == IDLE) && !lose_q && !win_q;
  assign seg_hit  = (seg_x[idx_q[IDX_W-1:0]] == head_x_q) && (seg_y[idx_q[IDX_W-1:0]] == head_y_q);
  assign a        = |amatch_q;
  assign w        = |wmatch_q;
  // Score is evaluated one bit wider so both underflow and overflow show up in the top bit;
  // only a lone wall hit can underflow and only a lone apple hit can overflow.
  assign sum        = {1'b0, points_q} + (POINT_W+1)'(a) - (POINT_W+1)'(w);
  assign new_points = sum[POINT_W] ? (w ? '0 : '1) : sum[POINT_W-1:0];
  assign lose_set   = body_q || (w && (new_points == '0));
  assign win_set    = (new_points >= POINT_W'(WIN_POINTS)) && !lose_set;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: single-segment snakes skip the scan entirely
  always_comb begin
    state_d = (state_q == IDLE) ? (accept ? ((len_eff > LEN_W'(1)) ? SCAN : RESOLVE) : IDLE) :
              (state_q == SCAN) ? ((idx_q == last_idx) ? RESOLVE : SCAN) : IDLE;
  end

  // FSM outputs
  always_comb begin
    busy      = (state_q != IDLE);
    done      = done_q;
    apple_hit = apple_hit_q;
    wall_hit  = wall_hit_q;
    points    = points_q;
    lose      = lose_q;
    win       = win_q;
  end

  // Datapath next values: capture on accept, accumulate body hits while scanning, score on resolve
  always_comb begin
    head_x_d    = accept ? seg_x[0] : head_x_q;
    head_y_d    = accept ? seg_y[0] : head_y_q;
    len_d       = accept ? len_eff : len_q;
    amatch_d    = accept ? amatch_now : amatch_q;
    wmatch_d    = accept ? wmatch_now : wmatch_q;
    body_d      = accept ? 1'b0 : (state_q == SCAN) ? (body_q | seg_hit) : body_q;
    idx_d       = accept ? LEN_W'(1) : ((state_q == SCAN) && (idx_q != last_idx)) ? idx_q + LEN_W'(1) : idx_q;
    apple_hit_d = accept ? '0 : (state_q == RESOLVE) ? amatch_q : apple_hit_q;
    wall_hit_d  = accept ? 1'b0 : (state_q == RESOLVE) ? w : wall_hit_q;
    points_d    = (state_q == RESOLVE) ? new_points : points_q;
    lose_d      = lose_q | ((state_q == RESOLVE) && lose_set);
    win_d       = win_q | ((state_q == RESOLVE) && win_set);
    done_d      = (state_q == RESOLVE);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_x_q    <= '0;
      head_y_q    <= '0;
      len_q       <= LEN_W'(1);
      idx_q       <= LEN_W'(1);
      body_q      <= 1'b0;
      amatch_q    <= '0;
      wmatch_q    <= '0;
      apple_hit_q <= '0;
      wall_hit_q  <= 1'b0;
      points_q    <= POINT_W'(START_POINTS);
      lose_q      <= 1'b0;
      win_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      head_x_q    <= head_x_d;
      head_y_q    <= head_y_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      body_q      <= body_d;
      amatch_q    <= amatch_d;
      wmatch_q    <= wmatch_d;
      apple_hit_q <= apple_hit_d;
      wall_hit_q  <= wall_hit_d;
      points_q    <= points_d;
      lose_q      <= lose_d;
      win_q       <= win_d;
      done_q      <= done_d;
    end
  end
endmodule

// File: tb/tb_snake_collision_engine.sv
// tb_snake_collision_engine: table-driven directed vectors plus hand sequences for ignore/abort corners
module tb_snake_collision_engine;
  localparam int CW = 11;
  localparam int ML = 23;
  localparam int LW = 6;
  localparam int NA = 2;
  localparam int NW = 4;
  localparam int PW = 6;

  logic              clk = 0;
  logic              reset = 1;
  logic              step = 0;
  logic [ML*CW-1:0]  snakepos_x, snakepos_y;
  logic [LW-1:0]     length;
  logic [NA*CW-1:0]  applepos_x, applepos_y;
  logic [NW*CW-1:0]  wallpos_x, wallpos_y;
  logic              busy, done, wall_hit, lose, win;
  logic [NA-1:0]     apple_hit;
  logic [PW-1:0]     points;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit       rst;
    int       len;
    int       hx;
    int       hy;
    int       body;
    bit [1:0] am;
    bit [3:0] wm;
    int       lat;
    bit [1:0] ea;
    bit       ew;
    int       ep;
    bit       el;
    bit       ewin;
  } vec_t;

  vec_t v[$];

  snake_collision_engine dut (
    .clk(clk), .reset(reset), .step(step),
    .snakepos_x(snakepos_x), .snakepos_y(snakepos_y), .length(length),
    .applepos_x(applepos_x), .applepos_y(applepos_y),
    .wallpos_x(wallpos_x), .wallpos_y(wallpos_y),
    .busy(busy), .done(done), .apple_hit(apple_hit), .wall_hit(wall_hit),
    .points(points), .lose(lose), .win(win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_pos(input vec_t t);
    for (int i = 0; i < ML; i++) begin
      snakepos_x[i*CW +: CW] = CW'(500 + i);
      snakepos_y[i*CW +: CW] = CW'(600);
    end
    snakepos_x[0 +: CW] = CW'(t.hx);
    snakepos_y[0 +: CW] = CW'(t.hy);
    if (t.body > 0) begin
      snakepos_x[t.body*CW +: CW] = CW'(t.hx);
      snakepos_y[t.body*CW +: CW] = CW'(t.hy);
    end
    applepos_x[0 +: CW] = CW'(300); applepos_y[0 +: CW] = CW'(70);
    applepos_x[CW +: CW] = CW'(100); applepos_y[CW +: CW] = CW'(50);
    for (int k = 0; k < NA; k++)
      if (t.am[k]) begin
        applepos_x[k*CW +: CW] = CW'(t.hx);
        applepos_y[k*CW +: CW] = CW'(t.hy);
      end
    for (int k = 0; k < NW; k++) begin
      wallpos_x[k*CW +: CW] = t.wm[k] ? CW'(t.hx) : CW'(10 + k);
      wallpos_y[k*CW +: CW] = t.wm[k] ? CW'(t.hy) : CW'(20);
    end
    length = LW'(t.len);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    #1;
    chk("rst_points", points, 2);
    chk("rst_flags", {busy, done, wall_hit, lose, win}, 0);
    chk("rst_apple_hit", apple_hit, 0);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic do_step(output int n);
    @(negedge clk);
    step = 1;
    @(posedge clk);
    #1 step = 0;
    n = 1;
    chk("busy_after_accept", busy, 1);
    chk("hits_cleared_on_accept", {apple_hit, wall_hit}, 0);
    while (!done && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic ign_step(input string nm, input int exp_pts);
    bit seen;
    seen = 0;
    @(negedge clk);
    step = 1;
    @(posedge clk);
    #1 step = 0;
    chk({nm, "_busy"}, busy, 0);
    repeat (5) begin
      @(posedge clk);
      #1 if (done || busy) seen = 1;
    end
    chk({nm, "_no_done"}, seen, 0);
    chk({nm, "_points"}, points, exp_pts);
  endtask

  initial begin
    int n;
    bit seen;
    vec_t t;
    //            rst len  hx   hy  body am     wm       lat ea    ew ep el win
    v.push_back('{1,  4,   1,   1,  0,   2'b00, 4'b0000, 5,  2'b00, 0, 2, 0, 0});
    v.push_back('{0,  3,   100, 50, 0,   2'b00, 4'b0000, 4,  2'b10, 0, 3, 0, 0});
    v.push_back('{0,  0,   7,   7,  0,   2'b11, 4'b0000, 2,  2'b11, 0, 4, 0, 0});
    v.push_back('{0,  1,   7,   7,  0,   2'b01, 4'b0000, 2,  2'b01, 0, 5, 0, 0});
    v.push_back('{0,  2,   7,   7,  5,   2'b01, 4'b0000, 3,  2'b01, 0, 6, 0, 0});
    v.push_back('{0,  23,  7,   7,  0,   2'b10, 4'b0000, 24, 2'b10, 0, 7, 0, 0});
    v.push_back('{0,  40,  7,   7,  0,   2'b01, 4'b0100, 24, 2'b01, 1, 7, 0, 0});
    v.push_back('{0,  5,   7,   7,  0,   2'b01, 4'b0000, 6,  2'b01, 0, 8, 0, 0});
    v.push_back('{0,  5,   7,   7,  0,   2'b01, 4'b0000, 6,  2'b01, 0, 9, 0, 1});
    v.push_back('{1,  5,   7,   7,  3,   2'b00, 4'b0000, 6,  2'b00, 0, 2, 1, 0});
    v.push_back('{1,  2,   7,   7,  0,   2'b00, 4'b0001, 3,  2'b00, 1, 1, 0, 0});
    v.push_back('{0,  2,   7,   7,  0,   2'b00, 4'b0001, 3,  2'b00, 1, 0, 1, 0});
    v.push_back('{1,  1,   7,   7,  0,   2'b01, 4'b0000, 2,  2'b01, 0, 3, 0, 0});
    v.push_back('{0,  1,   7,   7,  0,   2'b01, 4'b0000, 2,  2'b01, 0, 4, 0, 0});
    v.push_back('{0,  1,   7,   7,  0,   2'b01, 4'b0000, 2,  2'b01, 0, 5, 0, 0});
    v.push_back('{0,  1,   7,   7,  0,   2'b01, 4'b0000, 2,  2'b01, 0, 6, 0, 0});
    v.push_back('{0,  1,   7,   7,  0,   2'b01, 4'b0000, 2,  2'b01, 0, 7, 0, 0});
    v.push_back('{0,  1,   7,   7,  0,   2'b01, 4'b0000, 2,  2'b01, 0, 8, 0, 0});
    v.push_back('{0,  4,   7,   7,  3,   2'b01, 4'b0000, 5,  2'b01, 0, 9, 1, 0});

    t = v[0];
    set_pos(t);
    repeat (2) @(posedge clk);

    for (int k = 0; k < v.size(); k++) begin
      if (v[k].rst) do_reset();
      else if (k > 0) chk($sformatf("v%0d_hits_held", k), {apple_hit, wall_hit}, {v[k-1].ea, v[k-1].ew});
      set_pos(v[k]);
      do_step(n);
      chk($sformatf("v%0d_latency", k), n, v[k].lat);
      chk($sformatf("v%0d_busy_at_done", k), busy, 0);
      chk($sformatf("v%0d_apple_hit", k), apple_hit, v[k].ea);
      chk($sformatf("v%0d_wall_hit", k), wall_hit, v[k].ew);
      chk($sformatf("v%0d_points", k), points, v[k].ep);
      chk($sformatf("v%0d_lose", k), lose, v[k].el);
      chk($sformatf("v%0d_win", k), win, v[k].ewin);
      @(posedge clk);
      #1 chk($sformatf("v%0d_done_one_cycle", k), done, 0);
      if (k == 8) ign_step("win_ignore", 9);
      if (k == 9) ign_step("lose_ignore", 2);
    end

    do_reset();
    t = v[0];
    t.len = 40;
    t.am = 2'b01;
    set_pos(t);
    @(negedge clk);
    step = 1;
    @(posedge clk);
    #1 step = 0;
    repeat (9) @(posedge clk);
    #1 chk("abort_busy_before", busy, 1);
    reset = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_points", points, 2);
    @(negedge clk);
    reset = 0;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1 if (done || busy) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_apple_hit", apple_hit, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
